instruction_fetch: RTL

Front stage of the pipeline: issues instruction reads to memory, tags each with its PC, buffers returned words in a small in-order queue, and presents them to decode as pc/instruction pairs. It stops fetching when decode reports a pending PC change and resumes from the next_pc/has_flushed redirect issued by the write stage. While a redirect is outstanding it discards stale responses, so decode never sees a wrong-path instruction.

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues word reads, tags them with their PC, and
// buffers in-order returns in a small queue feeding decode as pc/instruction pairs.
module instruction_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_wait,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic        has_flushed,
  input  logic [31:0] next_pc,
  input  logic        is_pc_changing,
  input  logic        hold,
  output logic        is_valid,
  output logic [31:0] pc,
  output logic [31:0] instruction
);
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h8000_0000;

  typedef enum logic [1:0] {EMPTY, PENDING, READY} slot_t;
  typedef enum logic {RUN, FROZEN} state_t;

  state_t                 state;
  logic                   running;
  logic [31:0]            fetch_pc;
  slot_t                  slot_st [DEPTH];
  logic [DEPTH-1:0][31:0] slot_pc;
  logic [DEPTH-1:0][31:0] slot_data;
  logic [PW-1:0]          head, tail, rptr;
  logic [CW-1:0]          used, pend, discard;
  logic                   accept, pop, fill, drop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue depends only on registered state; 'running' keeps mem_read low
  // throughout reset and raises it on the first edge afterwards.
  assign mem_read    = running && (state == RUN) && (used < CW'(DEPTH)) &&
                       ((pend + discard) < CW'(DEPTH));
  assign mem_address = fetch_pc;
  assign is_valid    = (slot_st[head] == READY);
  assign pc          = is_valid ? slot_pc[head] : '0;
  assign instruction = is_valid ? slot_data[head] : NOP;

  assign accept = mem_read && !mem_wait;
  assign pop    = is_valid && !hold;
  assign drop   = mem_valid && (discard != '0);
  // A return with nothing pending and nothing to discard is ignored.
  assign fill   = mem_valid && (discard == '0) && (pend != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      running   <= 1'b0;
      fetch_pc  <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      rptr      <= '0;
      used      <= '0;
      pend      <= '0;
      discard   <= '0;
      slot_pc   <= '0;
      slot_data <= '0;
      for (int i = 0; i < DEPTH; i++) slot_st[i] <= EMPTY;
    end else begin
      running <= 1'b1;
      if (has_flushed) begin
        // Everything still in flight, including this cycle's issue, comes back
        // stale; the return arriving now is the first of those.
        state    <= RUN;
        fetch_pc <= next_pc;
        head     <= '0;
        tail     <= '0;
        rptr     <= '0;
        used     <= '0;
        pend     <= '0;
        discard  <= discard + pend + CW'(accept) - CW'(drop || fill);
        for (int i = 0; i < DEPTH; i++) slot_st[i] <= EMPTY;
      end else begin
        if (state == RUN && is_pc_changing) state <= FROZEN;
        if (drop) discard <= discard - 1'b1;
        if (fill) begin
          slot_st[rptr]   <= READY;
          slot_data[rptr] <= mem_data;
          rptr            <= nxt(rptr);
        end
        if (accept) begin
          slot_st[tail] <= PENDING;
          slot_pc[tail] <= fetch_pc;
          tail          <= nxt(tail);
          fetch_pc      <= fetch_pc + 32'd4;
        end
        if (pop) begin
          slot_st[head] <= EMPTY;
          head          <= nxt(head);
        end
        used <= used + CW'(accept) - CW'(pop);
        pend <= pend + CW'(accept) - CW'(fill);
      end
    end
  end
endmodule
